// File: rtl/io_dec_pkg.sv
// Shared types, widths and address-match helper for the IO space decoder.
package io_dec_pkg;

   localparam int unsigned WAIT_W = 4;
   localparam int unsigned TO_W   = 8;
   localparam int unsigned MAX_CH = 16;
   localparam int unsigned MAX_AW = 32;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_DECODE = 3'd1;
   localparam state_t ST_WAIT   = 3'd2;
   localparam state_t ST_ACK    = 3'd3;
   localparam state_t ST_NOMAP  = 3'd4;
   localparam state_t ST_ERR    = 3'd5;
   localparam state_t ST_DONE   = 3'd6;

   // Channel i matches when every mask-selected bit of addr equals its base.
   function automatic logic [MAX_CH-1:0] match_vec(
      input logic [MAX_AW-1:0]        addr,
      input logic [MAX_CH*MAX_AW-1:0] base,
      input logic [MAX_CH*MAX_AW-1:0] mask
   );
      logic [MAX_CH-1:0] m;
      m = '0;
      for (int i = 0; i < int'(MAX_CH); i++) begin
         m[i] = ~|((addr ^ base[i*MAX_AW +: MAX_AW]) & mask[i*MAX_AW +: MAX_AW]);
      end
      return m;
   endfunction

endpackage

// File: rtl/io_bus_decoder_ws_if.sv
// 68k IO bus bundle between the CPU side (master) and the decoder (slave).
interface io_bus_decoder_ws_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned ADDR_W = 16
);
   logic [ADDR_W-1:0] Address;
   logic              IO_Select_H;
   logic              AS_L;
   logic [NUM_CH-1:0] Enable_H;
   logic [NUM_CH-1:0] Strobe_H;
   logic              DTACK_L;
   logic              BERR_L;
   logic              Busy_H;

   modport master (
      output Address, IO_Select_H, AS_L,
      input  Enable_H, Strobe_H, DTACK_L, BERR_L, Busy_H
   );

   modport slave (
      input  Address, IO_Select_H, AS_L,
      output Enable_H, Strobe_H, DTACK_L, BERR_L, Busy_H
   );
endinterface

// File: rtl/io_dec_prio_enc.sv
// Lowest-index-wins priority encoder, purely combinational.
module io_dec_prio_enc #(
   parameter  int unsigned N     = 4,
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   output logic [IDX_W-1:0] idx_c,
   output logic             valid_c
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx_c   = '0;
      valid_c = 1'b0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx_c   = IDX_W'(i);
            valid_c = 1'b1;
         end
      end
   end

endmodule

// File: rtl/io_bus_decoder_ws.sv
// Multi-channel 68k IO decoder: per-channel enable/strobe, wait-state DTACK
// generation and BERR on timeout for unmapped accesses.
module io_bus_decoder_ws
   import io_dec_pkg::*;
#(
   parameter int unsigned              NUM_CH  = 4,
   parameter int unsigned              ADDR_W  = 16,
   parameter logic [NUM_CH*ADDR_W-1:0] CH_BASE = {16'h8020, 16'h8000, 16'h0030, 16'h0010},
   parameter logic [NUM_CH*ADDR_W-1:0] CH_MASK = {4{16'hFFF0}},
   parameter logic [NUM_CH*WAIT_W-1:0] CH_WAIT = {4'd0, 4'd2, 4'd1, 4'd0},
   parameter int unsigned              TIMEOUT = 64
) (
   input logic                Clk,
   input logic                Reset_H,
   io_bus_decoder_ws_if.slave bus
);

   localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [MAX_CH*MAX_AW-1:0] base_x;
   logic [MAX_CH*MAX_AW-1:0] mask_x;
   logic [WAIT_W-1:0]        wait_tbl [NUM_CH];
   logic [MAX_CH-1:0]        match_all;
   logic [NUM_CH-1:0]        match;
   logic                     unused_match;
   logic [IDX_W-1:0]         enc_idx;
   logic                     enc_valid;
   logic [NUM_CH-1:0]        enc_onehot;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  ch_q, ch_d;
   logic              vld_q, vld_d;
   logic [WAIT_W-1:0] wcnt_q, wcnt_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic [NUM_CH-1:0] en_q, en_d;
   logic [NUM_CH-1:0] stb_q, stb_d;
   logic              dtack_q, dtack_d;
   logic              berr_q, berr_d;
   logic              busy_q, busy_d;

   // Widen the per-channel parameter tables to the helper's fixed layout.
   always_comb begin
      base_x = '0;
      mask_x = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         base_x[i*MAX_AW +: MAX_AW] = MAX_AW'(CH_BASE[i*ADDR_W +: ADDR_W]);
         mask_x[i*MAX_AW +: MAX_AW] = MAX_AW'(CH_MASK[i*ADDR_W +: ADDR_W]);
         wait_tbl[i]                = CH_WAIT[i*WAIT_W +: WAIT_W];
      end
   end

   assign match_all    = match_vec(MAX_AW'(bus.Address), base_x, mask_x);
   assign match        = match_all[NUM_CH-1:0];
   assign unused_match = ^match_all;

   io_dec_prio_enc #(.N(NUM_CH)) u_prio_enc (
      .req     (match),
      .idx_c   (enc_idx),
      .valid_c (enc_valid)
   );

   assign enc_onehot = NUM_CH'(1) << enc_idx;

   always_ff @(posedge Clk or posedge Reset_H) begin
      if (Reset_H) begin
         state_q <= ST_IDLE;
         ch_q    <= '0;
         vld_q   <= 1'b0;
         wcnt_q  <= '0;
         to_q    <= '0;
         en_q    <= '0;
         stb_q   <= '0;
         dtack_q <= 1'b1;
         berr_q  <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         vld_q   <= vld_d;
         wcnt_q  <= wcnt_d;
         to_q    <= to_d;
         en_q    <= en_d;
         stb_q   <= stb_d;
         dtack_q <= dtack_d;
         berr_q  <= berr_d;
         busy_q  <= busy_d;
      end
   end

   // Next state and next registered outputs; AS_L high always ends the cycle.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      vld_d   = vld_q;
      wcnt_d  = wcnt_q;
      to_d    = to_q;
      en_d    = en_q;
      stb_d   = '0;
      dtack_d = 1'b1;
      berr_d  = 1'b1;

      case (state_q)
         ST_IDLE: begin
            en_d = '0;
            if (!bus.AS_L && bus.IO_Select_H) begin
               state_d = ST_DECODE;
               ch_d    = enc_idx;
               vld_d   = enc_valid;
               if (enc_valid) begin
                  en_d  = enc_onehot;
                  stb_d = enc_onehot;
               end
            end
         end
         ST_DECODE: begin
            if (bus.AS_L) begin
               state_d = ST_IDLE;
               en_d    = '0;
            end else if (vld_q) begin
               wcnt_d  = wait_tbl[ch_q];
               state_d = (wait_tbl[ch_q] != '0) ? ST_WAIT : ST_ACK;
            end else begin
               to_d    = TO_W'(TIMEOUT - 1);
               state_d = ST_NOMAP;
            end
         end
         ST_WAIT: begin
            if (bus.AS_L) begin
               state_d = ST_IDLE;
               en_d    = '0;
            end else begin
               if (wcnt_q != '0) wcnt_d = wcnt_q - WAIT_W'(1);
               if (wcnt_q <= WAIT_W'(1)) state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if (bus.AS_L) begin
               state_d = ST_IDLE;
               en_d    = '0;
            end else begin
               dtack_d = 1'b0;
            end
         end
         ST_NOMAP: begin
            if (bus.AS_L) begin
               state_d = ST_IDLE;
            end else if (to_q == '0) begin
               state_d = ST_ERR;
               berr_d  = 1'b0;
            end else begin
               to_d = to_q - TO_W'(1);
            end
         end
         ST_ERR: begin
            if (bus.AS_L) state_d = ST_IDLE;
            else          berr_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            en_d    = '0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign bus.Enable_H = en_q;
   assign bus.Strobe_H = stb_q;
   assign bus.DTACK_L  = dtack_q;
   assign bus.BERR_L   = berr_q;
   assign bus.Busy_H   = busy_q;

endmodule
